// File: rtl/sccb_responder.sv
// Write-only SCCB responder: decodes START/ID/ADDR/DATA/STOP and reports each completed write.
// Define SCCB_RESPONDER_REGFILE_EN to add a 256x8 register file read through rd_addr/rd_data.
module sccb_responder #(
    parameter logic [7:0] DEVICE_ID   = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sioc,
    inout  wire        siod,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] txn_count,
    output logic       busy,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ID       = 3'd1;
    localparam logic [2:0] S_ID_ACK   = 3'd2;
    localparam logic [2:0] S_ADDR     = 3'd3;
    localparam logic [2:0] S_ADDR_ACK = 3'd4;
    localparam logic [2:0] S_DATA     = 3'd5;
    localparam logic [2:0] S_DATA_ACK = 3'd6;
    localparam logic [2:0] S_IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] sioc_sync;
    logic [SYNC_STAGES-1:0] siod_sync;
    logic                   sioc_q;
    logic                   siod_q;
    logic                   sioc_s;
    logic                   siod_s;

    // Synchronizers reset to 1 so the bus looks idle right after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sioc_sync <= '1;
            siod_sync <= '1;
            sioc_q    <= 1'b1;
            siod_q    <= 1'b1;
        end else begin
            sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
            siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod};
            sioc_q    <= sioc_s;
            siod_q    <= siod_s;
        end
    end

    assign sioc_s = sioc_sync[SYNC_STAGES-1];
    assign siod_s = siod_sync[SYNC_STAGES-1];

    logic sioc_rise;
    logic sioc_fall;
    logic start_cond;
    logic stop_cond;

    assign sioc_rise  = sioc_s & ~sioc_q;
    assign sioc_fall  = ~sioc_s & sioc_q;
    assign start_cond = sioc_s & sioc_q & siod_q & ~siod_s;
    assign stop_cond  = sioc_s & sioc_q & ~siod_q & siod_s;

    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic       drive_low;
    logic       byte_phase;
    logic       byte_full;

    assign byte_phase = (state == S_ID) || (state == S_ADDR) || (state == S_DATA);
    assign byte_full  = (bit_cnt == 4'd8);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            drive_low <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            txn_count <= 8'h00;
        end else begin
            wr_valid <= 1'b0;
            if (start_cond) begin
                state     <= S_ID;
                bit_cnt   <= 4'd0;
                drive_low <= 1'b0;
            end else if (stop_cond) begin
                state     <= S_IDLE;
                drive_low <= 1'b0;
            end else if (sioc_rise && byte_phase && !byte_full) begin
                bit_cnt <= bit_cnt + 4'd1;
            end else if (sioc_fall) begin
                // ACK is driven from the falling edge after bit 8 to the next falling edge.
                case (state)
                    S_ID: if (byte_full) begin
                        if (shift == DEVICE_ID) begin
                            state     <= S_ID_ACK;
                            drive_low <= 1'b1;
                        end else begin
                            state <= S_IGNORE;
                        end
                    end
                    S_ADDR: if (byte_full) begin
                        state     <= S_ADDR_ACK;
                        drive_low <= 1'b1;
                    end
                    S_DATA: if (byte_full) begin
                        state     <= S_DATA_ACK;
                        drive_low <= 1'b1;
                    end
                    S_ID_ACK: begin
                        state     <= S_ADDR;
                        bit_cnt   <= 4'd0;
                        drive_low <= 1'b0;
                    end
                    S_ADDR_ACK: begin
                        state     <= S_DATA;
                        bit_cnt   <= 4'd0;
                        drive_low <= 1'b0;
                    end
                    S_DATA_ACK: begin
                        state     <= S_IGNORE;
                        drive_low <= 1'b0;
                        wr_valid  <= 1'b1;
                        wr_addr   <= addr_q;
                        wr_data   <= data_q;
                        txn_count <= txn_count + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sioc_rise && byte_phase && !byte_full)
            shift <= {shift[6:0], siod_s};
        if (sioc_fall && state == S_ADDR && byte_full)
            addr_q <= shift;
        if (sioc_fall && state == S_DATA && byte_full)
            data_q <= shift;
    end

    assign siod = drive_low ? 1'b0 : 1'bz;
    assign busy = (state != S_IDLE);

`ifdef SCCB_RESPONDER_REGFILE_EN
    logic [7:0] regs [256];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++)
                regs[i] <= 8'h00;
            rd_data <= 8'h00;
        end else begin
            if (wr_valid)
                regs[wr_addr] <= wr_data;
            rd_data <= regs[rd_addr];
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_data   = 8'h00;
`endif

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: bit-banged SCCB master plus a transaction-level model.
module tb_sccb_responder;
    localparam logic [7:0] DEV = 8'h42;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sioc = 1'b1;
    logic       msda = 1'b1;
    logic [7:0] rd_addr = 8'h00;
    wire        siod;
    logic       wr_valid;
    logic       busy;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] txn_count;
    logic [7:0] rd_data;

    assign siod = msda ? 1'bz : 1'b0;
    pullup (siod);

    always #5 clk = ~clk;

    sccb_responder #(.DEVICE_ID(DEV), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sioc      (sioc),
        .siod      (siod),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .txn_count (txn_count),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: expected outcome of each transaction.
    logic [7:0] mem [256];
    int         exp_cnt = 0;
    logic [7:0] exp_addr = 8'h00;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] fq [$];

    int   pulses = 0;
    int   long_pulses = 0;
    logic wv_prev = 1'b0;

    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            pulses++;
            if (wv_prev === 1'b1) long_pulses++;
        end
        wv_prev = wr_valid;
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        msda = 1'b1; w(2);
        sioc = 1'b1; w(2);
        msda = 1'b0; w(2);
        sioc = 1'b0; w(3);
    endtask

    task automatic m_stop();
        msda = 1'b0; w(3);
        sioc = 1'b1; w(3);
        msda = 1'b1; w(3);
    endtask

    task automatic m_bit(input logic b);
        msda = b;    w(2);
        sioc = 1'b1; w(3);
        sioc = 1'b0; w(3);
    endtask

    task automatic m_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) m_bit(b[i]);
        msda = 1'b1; w(2);
        sioc = 1'b1; w(3);
        ack = (siod === 1'b0);
        sioc = 1'b0; w(3);
    endtask

    task automatic model_reset();
        exp_cnt  = 0;
        exp_addr = 8'h00;
        exp_data = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Sends START, the bytes in fq, STOP and checks ACKs and the resulting write.
    task automatic run_frame(input string tag);
        int   p0;
        logic ack;
        bit   wr_exp;
        p0 = pulses;
        m_start();
        check($sformatf("%s_busy", tag), busy, 1);
        foreach (fq[i]) begin
            m_byte(fq[i], ack);
            check($sformatf("%s_ack%0d", tag, i), ack, (fq[0] == DEV && i <= 2));
        end
        m_stop();
        w(2);
        wr_exp = (fq.size() >= 3) && (fq[0] == DEV);
        if (wr_exp) begin
            exp_cnt  = (exp_cnt + 1) % 256;
            exp_addr = fq[1];
            exp_data = fq[2];
            mem[fq[1]] = fq[2];
        end
        check($sformatf("%s_writes", tag), pulses - p0, wr_exp);
        check($sformatf("%s_busy_end", tag), busy, 0);
        check($sformatf("%s_addr", tag), wr_addr, exp_addr);
        check($sformatf("%s_data", tag), wr_data, exp_data);
        check($sformatf("%s_count", tag), txn_count, exp_cnt);
    endtask

    task automatic check_read(input string tag, input logic [7:0] a);
        rd_addr = a;
        w(1);
`ifdef SCCB_RESPONDER_REGFILE_EN
        check(tag, rd_data, mem[a]);
`else
        check(tag, rd_data, 8'h00);
`endif
    endtask

    initial begin
        #1_200_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        int         p0;
        int         n;
        logic [7:0] written [$];

        model_reset();
        w(3);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_count", txn_count, 0);
        check("rst_busy", busy, 0);
        check("rst_siod", siod, 1);
        check("rst_rd_data", rd_data, 0);
        reset_n = 1'b1;
        w(4);
        check("idle_busy", busy, 0);

        fq = '{DEV, 8'h12, 8'h80};
        run_frame("basic");
        check_read("basic_rd", 8'h12);

        fq = '{8'h60, 8'h12, 8'h80};
        run_frame("wrong_id");

        fq = '{8'h43, 8'h55, 8'h66};
        run_frame("read_id");

        fq = '{DEV, 8'h3A};
        run_frame("short");

        // Repeated START in the middle of the data byte restarts the transaction.
        p0 = pulses;
        m_start();
        m_byte(DEV, ack);
        check("rs_ack_id", ack, 1);
        m_byte(8'h3A, ack);
        check("rs_ack_addr", ack, 1);
        m_bit(1'b1); m_bit(1'b0); m_bit(1'b1);
        check("rs_no_write", pulses - p0, 0);
        fq = '{DEV, 8'h3A, 8'h04};
        run_frame("restart");

        // Reset in the middle of the data byte aborts without a write.
        p0 = pulses;
        m_start();
        m_byte(DEV, ack);
        m_byte(8'h12, ack);
        for (int i = 7; i >= 3; i--) m_bit(i[0]);
        msda = 1'b1; w(1);
        reset_n = 1'b0;
        w(2);
        check("mid_rst_siod", siod, 1);
        check("mid_rst_valid", wr_valid, 0);
        check("mid_rst_addr", wr_addr, 0);
        check("mid_rst_data", wr_data, 0);
        check("mid_rst_count", txn_count, 0);
        check("mid_rst_busy", busy, 0);
        reset_n = 1'b1;
        model_reset();
        sioc = 1'b1; w(3);
        sioc = 1'b0; w(3);
        m_stop();
        w(2);
        check("mid_rst_no_write", pulses - p0, 0);
        check_read("mid_rst_rd", 8'h12);
        fq = '{DEV, 8'h12, 8'h99};
        run_frame("after_rst");

        // Random frames: device or stray ID, 0..5 bytes.
        for (int k = 0; k < 20; k++) begin
            fq.delete();
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) fq.push_back(8'($urandom));
            if (n > 0 && $urandom_range(0, 3) != 0) fq[0] = DEV;
            if (n >= 3 && fq[0] == DEV) written.push_back(fq[1]);
            run_frame($sformatf("rnd%0d", k));
        end
        foreach (written[i]) check_read($sformatf("rnd_rd%0d", i), written[i]);

        // 256 back-to-back writes walk the counter through its wrap.
        for (int k = 0; k < 256; k++) begin
            fq = '{DEV, (k == 255) ? 8'h12 : 8'($urandom), 8'($urandom)};
            run_frame($sformatf("wrap%0d", k));
            if (exp_cnt == 0) check("wrap_zero", txn_count, 0);
        end
        check_read("final_rd12", 8'h12);
        check_read("final_rd_rand", written.size() > 0 ? written[0] : 8'h12);

        check("wr_valid_width", long_pulses, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
